// File: rtl/tl_mem_arb.sv
// Two-port TileLink-UL arbiter serialising whole transactions onto one tl_mem port.
// Latency: one arbitration cycle in IDLE, then A/D beats pass combinationally.
// Backpressure: a_ready/d_ready pass through to the granted port only; others wait.
// Build option TL_MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no round-robin).
module tl_mem_arb (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   tlslv0_a_opcode,
   input  logic [2:0]   tlslv0_a_param,
   input  logic [7:0]   tlslv0_a_size,
   input  logic [2:0]   tlslv0_a_source,
   input  logic [31:0]  tlslv0_a_address,
   input  logic [15:0]  tlslv0_a_mask,
   input  logic [127:0] tlslv0_a_data,
   input  logic         tlslv0_a_corrupt,
   input  logic         tlslv0_a_valid,
   output logic         tlslv0_a_ready,
   output logic [2:0]   tlslv0_d_opcode,
   output logic [1:0]   tlslv0_d_param,
   output logic [7:0]   tlslv0_d_size,
   output logic [2:0]   tlslv0_d_source,
   output logic [2:0]   tlslv0_d_sink,
   output logic         tlslv0_d_denied,
   output logic [127:0] tlslv0_d_data,
   output logic         tlslv0_d_corrupt,
   output logic         tlslv0_d_valid,
   input  logic         tlslv0_d_ready,
   input  logic [2:0]   tlslv1_a_opcode,
   input  logic [2:0]   tlslv1_a_param,
   input  logic [7:0]   tlslv1_a_size,
   input  logic [2:0]   tlslv1_a_source,
   input  logic [31:0]  tlslv1_a_address,
   input  logic [15:0]  tlslv1_a_mask,
   input  logic [127:0] tlslv1_a_data,
   input  logic         tlslv1_a_corrupt,
   input  logic         tlslv1_a_valid,
   output logic         tlslv1_a_ready,
   output logic [2:0]   tlslv1_d_opcode,
   output logic [1:0]   tlslv1_d_param,
   output logic [7:0]   tlslv1_d_size,
   output logic [2:0]   tlslv1_d_source,
   output logic [2:0]   tlslv1_d_sink,
   output logic         tlslv1_d_denied,
   output logic [127:0] tlslv1_d_data,
   output logic         tlslv1_d_corrupt,
   output logic         tlslv1_d_valid,
   input  logic         tlslv1_d_ready,
   output logic [2:0]   tlmst_a_opcode,
   output logic [2:0]   tlmst_a_param,
   output logic [7:0]   tlmst_a_size,
   output logic [2:0]   tlmst_a_source,
   output logic [31:0]  tlmst_a_address,
   output logic [15:0]  tlmst_a_mask,
   output logic [127:0] tlmst_a_data,
   output logic         tlmst_a_corrupt,
   output logic         tlmst_a_valid,
   input  logic         tlmst_a_ready,
   input  logic [2:0]   tlmst_d_opcode,
   input  logic [1:0]   tlmst_d_param,
   input  logic [7:0]   tlmst_d_size,
   input  logic [2:0]   tlmst_d_source,
   input  logic [2:0]   tlmst_d_sink,
   input  logic         tlmst_d_denied,
   input  logic [127:0] tlmst_d_data,
   input  logic         tlmst_d_corrupt,
   input  logic         tlmst_d_valid,
   output logic         tlmst_d_ready
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t     state_q, state_d;
   logic       grant_q, grant_d;   // 0 = port 0, 1 = port 1
   logic [2:0] a_cnt_q, a_cnt_d;
   logic [2:0] d_cnt_q, d_cnt_d;
   logic       any_vld;
   logic       win;
   logic [2:0] win_opcode;
   logic [7:0] win_size;

   // 16-byte beats: size 5 -> 2 beats, size 6 -> 4; larger sizes clamp to 4.
   function automatic logic [2:0] beats(input logic [7:0] size);
      if (size <= 8'd4)       beats = 3'd1;
      else if (size == 8'd5)  beats = 3'd2;
      else                    beats = 3'd4;
   endfunction

   assign any_vld = tlslv0_a_valid | tlslv1_a_valid;

`ifdef TL_MEM_ARB_FIXED_PRIO_EN
   // Port 0 wins whenever it is requesting.
   always_comb begin
      win = ~tlslv0_a_valid;
   end
`else
   logic rr_q, rr_d;   // port preferred on the next tie

   // Tie goes to the preferred port; a lone requester always wins.
   always_comb begin
      win = ~tlslv0_a_valid;
      if (tlslv0_a_valid && tlslv1_a_valid) win = rr_q;
   end

   // Prefer the other port once a grant is taken.
   always_comb begin
      rr_d = rr_q;
      if (state_q == IDLE && any_vld) rr_d = ~win;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
`endif

   assign win_opcode = win ? tlslv1_a_opcode : tlslv0_a_opcode;
   assign win_size   = win ? tlslv1_a_size   : tlslv0_a_size;

   // Next state: grant in IDLE, count A beats in REQ, count D beats in RESP.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      a_cnt_d = a_cnt_q;
      d_cnt_d = d_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_vld) begin
               grant_d = win;
               a_cnt_d = (win_opcode == 3'd0 || win_opcode == 3'd1) ? beats(win_size) : 3'd1;
               d_cnt_d = (win_opcode == 3'd4) ? beats(win_size) : 3'd1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (tlmst_a_valid && tlmst_a_ready) begin
               a_cnt_d = a_cnt_q - 3'd1;
               if (a_cnt_q == 3'd1) state_d = RESP;
            end
         end
         RESP: begin
            if (tlmst_d_valid && tlmst_d_ready) begin
               d_cnt_d = d_cnt_q - 3'd1;
               if (d_cnt_q == 3'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant and beat counters; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         a_cnt_q <= 3'd0;
         d_cnt_q <= 3'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         a_cnt_q <= a_cnt_d;
         d_cnt_q <= d_cnt_d;
      end
   end

   // A channel: granted port's fields go downstream; valid/ready gated by REQ.
   always_comb begin
      tlmst_a_opcode  = grant_q ? tlslv1_a_opcode  : tlslv0_a_opcode;
      tlmst_a_param   = grant_q ? tlslv1_a_param   : tlslv0_a_param;
      tlmst_a_size    = grant_q ? tlslv1_a_size    : tlslv0_a_size;
      tlmst_a_source  = grant_q ? tlslv1_a_source  : tlslv0_a_source;
      tlmst_a_address = grant_q ? tlslv1_a_address : tlslv0_a_address;
      tlmst_a_mask    = grant_q ? tlslv1_a_mask    : tlslv0_a_mask;
      tlmst_a_data    = grant_q ? tlslv1_a_data    : tlslv0_a_data;
      tlmst_a_corrupt = grant_q ? tlslv1_a_corrupt : tlslv0_a_corrupt;
      tlmst_a_valid   = (state_q == REQ) && (grant_q ? tlslv1_a_valid : tlslv0_a_valid);
      tlslv0_a_ready  = (state_q == REQ) && !grant_q && tlmst_a_ready;
      tlslv1_a_ready  = (state_q == REQ) &&  grant_q && tlmst_a_ready;
   end

   // D channel: payload broadcast to both ports; only the granted one sees valid in RESP.
   always_comb begin
      tlslv0_d_opcode  = tlmst_d_opcode;
      tlslv0_d_param   = tlmst_d_param;
      tlslv0_d_size    = tlmst_d_size;
      tlslv0_d_source  = tlmst_d_source;
      tlslv0_d_sink    = tlmst_d_sink;
      tlslv0_d_denied  = tlmst_d_denied;
      tlslv0_d_data    = tlmst_d_data;
      tlslv0_d_corrupt = tlmst_d_corrupt;
      tlslv1_d_opcode  = tlmst_d_opcode;
      tlslv1_d_param   = tlmst_d_param;
      tlslv1_d_size    = tlmst_d_size;
      tlslv1_d_source  = tlmst_d_source;
      tlslv1_d_sink    = tlmst_d_sink;
      tlslv1_d_denied  = tlmst_d_denied;
      tlslv1_d_data    = tlmst_d_data;
      tlslv1_d_corrupt = tlmst_d_corrupt;
      tlslv0_d_valid   = (state_q == RESP) && !grant_q && tlmst_d_valid;
      tlslv1_d_valid   = (state_q == RESP) &&  grant_q && tlmst_d_valid;
      tlmst_d_ready    = (state_q == RESP) && (grant_q ? tlslv1_d_ready : tlslv0_d_ready);
   end

endmodule

// File: tb/tb_tl_mem_arb.sv
// Directed bench for tl_mem_arb: single Get, round-robin, gapped Put, D stall, mid-flight reset.
module tb_tl_mem_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   s0_a_opcode, s0_a_param, s0_a_source;
   logic [7:0]   s0_a_size;
   logic [31:0]  s0_a_address;
   logic [15:0]  s0_a_mask;
   logic [127:0] s0_a_data;
   logic         s0_a_corrupt, s0_a_valid, s0_a_ready;
   logic [2:0]   s0_d_opcode, s0_d_source, s0_d_sink;
   logic [1:0]   s0_d_param;
   logic [7:0]   s0_d_size;
   logic         s0_d_denied, s0_d_corrupt, s0_d_valid, s0_d_ready;
   logic [127:0] s0_d_data;
   logic [2:0]   s1_a_opcode, s1_a_param, s1_a_source;
   logic [7:0]   s1_a_size;
   logic [31:0]  s1_a_address;
   logic [15:0]  s1_a_mask;
   logic [127:0] s1_a_data;
   logic         s1_a_corrupt, s1_a_valid, s1_a_ready;
   logic [2:0]   s1_d_opcode, s1_d_source, s1_d_sink;
   logic [1:0]   s1_d_param;
   logic [7:0]   s1_d_size;
   logic         s1_d_denied, s1_d_corrupt, s1_d_valid, s1_d_ready;
   logic [127:0] s1_d_data;
   logic [2:0]   m_a_opcode, m_a_param, m_a_source;
   logic [7:0]   m_a_size;
   logic [31:0]  m_a_address;
   logic [15:0]  m_a_mask;
   logic [127:0] m_a_data;
   logic         m_a_corrupt, m_a_valid, m_a_ready;
   logic [2:0]   m_d_opcode, m_d_source, m_d_sink;
   logic [1:0]   m_d_param;
   logic [7:0]   m_d_size;
   logic         m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
   logic [127:0] m_d_data;

   int n_vec = 0;
   int n_err = 0;
   int exp_port;

   always #5 clk = ~clk;

   tl_mem_arb dut (
      .clk(clk), .rst(rst),
      .tlslv0_a_opcode(s0_a_opcode), .tlslv0_a_param(s0_a_param), .tlslv0_a_size(s0_a_size),
      .tlslv0_a_source(s0_a_source), .tlslv0_a_address(s0_a_address), .tlslv0_a_mask(s0_a_mask),
      .tlslv0_a_data(s0_a_data), .tlslv0_a_corrupt(s0_a_corrupt), .tlslv0_a_valid(s0_a_valid),
      .tlslv0_a_ready(s0_a_ready),
      .tlslv0_d_opcode(s0_d_opcode), .tlslv0_d_param(s0_d_param), .tlslv0_d_size(s0_d_size),
      .tlslv0_d_source(s0_d_source), .tlslv0_d_sink(s0_d_sink), .tlslv0_d_denied(s0_d_denied),
      .tlslv0_d_data(s0_d_data), .tlslv0_d_corrupt(s0_d_corrupt), .tlslv0_d_valid(s0_d_valid),
      .tlslv0_d_ready(s0_d_ready),
      .tlslv1_a_opcode(s1_a_opcode), .tlslv1_a_param(s1_a_param), .tlslv1_a_size(s1_a_size),
      .tlslv1_a_source(s1_a_source), .tlslv1_a_address(s1_a_address), .tlslv1_a_mask(s1_a_mask),
      .tlslv1_a_data(s1_a_data), .tlslv1_a_corrupt(s1_a_corrupt), .tlslv1_a_valid(s1_a_valid),
      .tlslv1_a_ready(s1_a_ready),
      .tlslv1_d_opcode(s1_d_opcode), .tlslv1_d_param(s1_d_param), .tlslv1_d_size(s1_d_size),
      .tlslv1_d_source(s1_d_source), .tlslv1_d_sink(s1_d_sink), .tlslv1_d_denied(s1_d_denied),
      .tlslv1_d_data(s1_d_data), .tlslv1_d_corrupt(s1_d_corrupt), .tlslv1_d_valid(s1_d_valid),
      .tlslv1_d_ready(s1_d_ready),
      .tlmst_a_opcode(m_a_opcode), .tlmst_a_param(m_a_param), .tlmst_a_size(m_a_size),
      .tlmst_a_source(m_a_source), .tlmst_a_address(m_a_address), .tlmst_a_mask(m_a_mask),
      .tlmst_a_data(m_a_data), .tlmst_a_corrupt(m_a_corrupt), .tlmst_a_valid(m_a_valid),
      .tlmst_a_ready(m_a_ready),
      .tlmst_d_opcode(m_d_opcode), .tlmst_d_param(m_d_param), .tlmst_d_size(m_d_size),
      .tlmst_d_source(m_d_source), .tlmst_d_sink(m_d_sink), .tlmst_d_denied(m_d_denied),
      .tlmst_d_data(m_d_data), .tlmst_d_corrupt(m_d_corrupt), .tlmst_d_valid(m_d_valid),
      .tlmst_d_ready(m_d_ready)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      s0_a_opcode = '0; s0_a_param = '0; s0_a_size = '0; s0_a_source = '0; s0_a_address = '0;
      s0_a_mask = '0; s0_a_data = '0; s0_a_corrupt = 1'b0; s0_a_valid = 1'b0; s0_d_ready = 1'b0;
      s1_a_opcode = '0; s1_a_param = '0; s1_a_size = '0; s1_a_source = '0; s1_a_address = '0;
      s1_a_mask = '0; s1_a_data = '0; s1_a_corrupt = 1'b0; s1_a_valid = 1'b0; s1_d_ready = 1'b0;
      m_a_ready = 1'b1;
      m_d_opcode = '0; m_d_param = '0; m_d_size = '0; m_d_source = '0; m_d_sink = '0;
      m_d_denied = 1'b0; m_d_data = '0; m_d_corrupt = 1'b0; m_d_valid = 1'b0;

      // Reset holds IDLE even with a request pending.
      step();
      s0_a_valid = 1'b1;
      step();
      #1;
      chk("rst_mst_a_vld", m_a_valid, 1'b0);
      chk("rst_a_rdy0", s0_a_ready, 1'b0);
      chk("rst_a_rdy1", s1_a_ready, 1'b0);
      chk("rst_d_vld0", s0_d_valid, 1'b0);
      chk("rst_mst_d_rdy", m_d_ready, 1'b0);
      s0_a_valid = 1'b0;
      rst = 1'b0;

      // Port 0 Get 0x20 size 5: one A beat, two D beats.
      step();
      s0_a_opcode = 3'd4; s0_a_size = 8'd5; s0_a_source = 3'd2; s0_a_address = 32'h20;
      s0_a_mask = 16'hffff; s0_a_valid = 1'b1; s0_d_ready = 1'b1;
      #1;
      chk("t1_idle_mst_vld", m_a_valid, 1'b0);
      chk("t1_idle_a_rdy0", s0_a_ready, 1'b0);
      step();
      #1;
      chk("t1_req_mst_vld", m_a_valid, 1'b1);
      chk("t1_req_addr", m_a_address, 32'h20);
      chk("t1_req_size", m_a_size, 8'd5);
      chk("t1_req_a_rdy0", s0_a_ready, 1'b1);
      chk("t1_req_a_rdy1", s1_a_ready, 1'b0);
      step();
      s0_a_valid = 1'b0;
      m_d_valid = 1'b1; m_d_opcode = 3'd1; m_d_size = 8'd5; m_d_source = 3'd2; m_d_data = 128'hA1;
      #1;
      chk("t1_d0_vld_b0", s0_d_valid, 1'b1);
      chk("t1_d0_dat_b0", s0_d_data, 128'hA1);
      chk("t1_d1_vld_b0", s1_d_valid, 1'b0);
      chk("t1_mst_d_rdy", m_d_ready, 1'b1);
      chk("t1_resp_mst_a_vld", m_a_valid, 1'b0);
      step();
      m_d_data = 128'hA2;
      #1;
      chk("t1_d0_vld_b1", s0_d_valid, 1'b1);
      chk("t1_d0_dat_b1", s0_d_data, 128'hA2);
      chk("t1_d1_vld_b1", s1_d_valid, 1'b0);
      step();
      #1;
      chk("t1_done_d0_vld", s0_d_valid, 1'b0);
      chk("t1_done_mst_d_rdy", m_d_ready, 1'b0);
      m_d_valid = 1'b0;

      // Port 1 PutFullData size 5 with an idle cycle between beats.
      s1_a_opcode = 3'd0; s1_a_size = 8'd5; s1_a_source = 3'd5; s1_a_data = 128'd1;
      s1_a_mask = 16'hffff; s1_a_valid = 1'b1; s1_d_ready = 1'b1;
      step();
      #1;
      chk("t2_b0_mst_vld", m_a_valid, 1'b1);
      chk("t2_b0_dat", m_a_data, 128'd1);
      chk("t2_b0_opc", m_a_opcode, 3'd0);
      chk("t2_b0_a_rdy1", s1_a_ready, 1'b1);
      chk("t2_b0_a_rdy0", s0_a_ready, 1'b0);
      step();
      s1_a_valid = 1'b0;
      #1;
      chk("t2_gap_mst_vld", m_a_valid, 1'b0);
      chk("t2_gap_a_rdy0", s0_a_ready, 1'b0);
      step();
      s1_a_valid = 1'b1; s1_a_data = 128'd2;
      #1;
      chk("t2_b1_mst_vld", m_a_valid, 1'b1);
      chk("t2_b1_dat", m_a_data, 128'd2);
      chk("t2_b1_a_rdy0", s0_a_ready, 1'b0);
      step();
      s1_a_valid = 1'b0;
      m_d_valid = 1'b1; m_d_opcode = 3'd0; m_d_source = 3'd5; m_d_denied = 1'b1;
      #1;
      chk("t2_d1_vld", s1_d_valid, 1'b1);
      chk("t2_d1_denied", s1_d_denied, 1'b1);
      chk("t2_d1_src", s1_d_source, 3'd5);
      chk("t2_d0_vld", s0_d_valid, 1'b0);
      chk("t2_resp_mst_a_vld", m_a_valid, 1'b0);
      step();
      m_d_denied = 1'b0;
      #1;
      chk("t2_done_d1_vld", s1_d_valid, 1'b0);
      m_d_valid = 1'b0;

      // Both ports request Get size 4 continuously after a reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      s0_a_opcode = 3'd4; s0_a_size = 8'd4; s0_a_source = 3'd1; s0_a_valid = 1'b1;
      s1_a_opcode = 3'd4; s1_a_size = 8'd4; s1_a_source = 3'd6; s1_a_valid = 1'b1;
      s0_d_ready = 1'b1; s1_d_ready = 1'b1;
      m_d_valid = 1'b1; m_d_opcode = 3'd1; m_d_size = 8'd4;
      for (int k = 0; k < 4; k++) begin
`ifdef TL_MEM_ARB_FIXED_PRIO_EN
         exp_port = 0;
`else
         exp_port = k % 2;
`endif
         #1;
         chk("t3_idle_mst_vld", m_a_valid, 1'b0);
         chk("t3_idle_mst_d_rdy", m_d_ready, 1'b0);
         step();
         #1;
         chk("t3_req_src", m_a_source, (exp_port == 1) ? 3'd6 : 3'd1);
         chk("t3_req_a_rdy0", s0_a_ready, exp_port == 0);
         chk("t3_req_a_rdy1", s1_a_ready, exp_port == 1);
         chk("t3_req_mst_d_rdy", m_d_ready, 1'b0);
         step();
         #1;
         chk("t3_resp_d0_vld", s0_d_valid, exp_port == 0);
         chk("t3_resp_d1_vld", s1_d_valid, exp_port == 1);
         chk("t3_resp_mst_a_vld", m_a_valid, 1'b0);
         step();
      end

      // Port 0 holds d_ready low for 3 cycles in RESP.
      s1_a_valid = 1'b0;
      step();
      #1;
      chk("t4_req_mst_vld", m_a_valid, 1'b1);
      step();
      s0_a_valid = 1'b0; s0_d_ready = 1'b0; m_d_data = 128'hC3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_stall_mst_d_rdy", m_d_ready, 1'b0);
         chk("t4_stall_d0_vld", s0_d_valid, 1'b1);
         chk("t4_stall_d0_dat", s0_d_data, 128'hC3);
         step();
      end
      s0_d_ready = 1'b1;
      #1;
      chk("t4_go_mst_d_rdy", m_d_ready, 1'b1);
      step();
      #1;
      chk("t4_done_d0_vld", s0_d_valid, 1'b0);

      // Reset during the second D beat of a port-0 Get size 5.
      s0_a_size = 8'd5; s0_a_valid = 1'b1;
      step();
      #1;
      chk("t5_req_mst_vld", m_a_valid, 1'b1);
      step();
      s0_a_valid = 1'b0;
      #1;
      chk("t5_b0_d0_vld", s0_d_valid, 1'b1);
      step();
      rst = 1'b1; s0_d_ready = 1'b0;
      #1;
      chk("t5_b1_d0_vld", s0_d_valid, 1'b1);
      step();
      rst = 1'b0; s0_d_ready = 1'b1;
      s0_a_valid = 1'b1; s1_a_valid = 1'b1;
      #1;
      chk("t5_rst_a_rdy0", s0_a_ready, 1'b0);
      chk("t5_rst_a_rdy1", s1_a_ready, 1'b0);
      chk("t5_rst_d0_vld", s0_d_valid, 1'b0);
      chk("t5_rst_d1_vld", s1_d_valid, 1'b0);
      chk("t5_rst_mst_a_vld", m_a_valid, 1'b0);
      chk("t5_rst_mst_d_rdy", m_d_ready, 1'b0);
      step();
      #1;
      chk("t5_pref_mst_vld", m_a_valid, 1'b1);
      chk("t5_pref_src", m_a_source, 3'd1);
      chk("t5_pref_a_rdy1", s1_a_ready, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
